// File: rtl/pio_count_sequencer.sv
// pio_count_sequencer
//   Sole Avalon-MM master of the COUNT PIO data register. A prescaled
//   up/down counter is stepped on every prescaler tick and each new value
//   is pushed to the PIO with a single-cycle registered write. A 4-word
//   CSR slave lets the CPU configure, load, start/stop and monitor it.
//   CSR map:
//     0 CTRL   [0]EN [1]DIR [2]ONESHOT [3]IE [4]LOAD (pulse, reads 0),
//              [16 +: COUNT_W] preload value used by LOAD (write-only)
//     1 PERIOD tick every PERIOD+1 clocks
//     2 LIMIT  terminal value of the counter
//     3 STATUS read {DONE, count}; any write clears DONE
//   COUNT_W must not exceed 16 (preload lives in CTRL[31:16]).

module pio_count_sequencer #(
   parameter int          COUNT_W    = 16,
   parameter int          PRESCALE_W = 24,
   parameter logic [1:0]  PIO_ADDR   = 2'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   output logic        done_irq
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_PUSH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_PERIOD = 2'd1;
   localparam logic [1:0] A_LIMIT  = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   state_t                  state;
   logic                    en;
   logic                    dir;
   logic                    oneshot;
   logic                    ie;
   logic                    done;
   logic                    stop_pend;   // terminal value reached, enter DONE after its PUSH
   logic                    load_pend;   // LOAD arrived during PUSH, push it from RUN next
   logic [PRESCALE_W-1:0]   period;
   logic [PRESCALE_W-1:0]   prescale;
   logic [COUNT_W-1:0]      limit;
   logic [COUNT_W-1:0]      count;

   logic                    csr_wr;
   logic                    wr_ctrl;
   logic                    wr_period;
   logic                    wr_limit;
   logic                    wr_status;
   logic                    load;
   logic [COUNT_W-1:0]      load_val;
   logic                    en_eff;
   logic                    tick;
   logic [COUNT_W:0]        step_res;
   logic                    step_stop;
   logic [COUNT_W-1:0]      step_val;

   // Next counter value plus the oneshot-stop flag, packed as {stop, value}.
   // Up wraps on >= so a LIMIT lowered below the count still wraps to 0;
   // in oneshot mode the wrap is replaced by holding and stopping.
   function automatic logic [COUNT_W:0] step_count(
      input logic [COUNT_W-1:0] cnt,
      input logic [COUNT_W-1:0] lim,
      input logic               down,
      input logic               one
   );
      logic [COUNT_W-1:0] nxt;
      logic               stop;
      nxt  = cnt;
      stop = 1'b0;
      if (!down) begin
         if (cnt >= lim) begin
            if (one) stop = 1'b1;
            else     nxt  = '0;
         end else begin
            nxt  = cnt + COUNT_W'(1);
            stop = one && (nxt == lim);
         end
      end else begin
         if (cnt == '0) begin
            if (one) stop = 1'b1;
            else     nxt  = lim;
         end else begin
            nxt  = cnt - COUNT_W'(1);
            stop = one && (nxt == '0);
         end
      end
      return {stop, nxt};
   endfunction

   assign csr_wr    = chipselect && !write_n;
   assign wr_ctrl   = csr_wr && (address == A_CTRL);
   assign wr_period = csr_wr && (address == A_PERIOD);
   assign wr_limit  = csr_wr && (address == A_LIMIT);
   assign wr_status = csr_wr && (address == A_STATUS);
   assign load      = wr_ctrl && writedata[4];
   assign load_val  = writedata[16 +: COUNT_W];

   // A CTRL write in the same cycle decides EN for the transition, so a
   // start (or stop) takes effect without waiting for the register.
   assign en_eff    = wr_ctrl ? writedata[0] : en;
   assign tick      = (state == S_RUN) && (prescale >= period);

   assign step_res  = step_count(count, limit, dir, oneshot);
   assign step_stop = step_res[COUNT_W];
   assign step_val  = step_res[COUNT_W-1:0];

   assign m_address = PIO_ADDR;
   assign done_irq  = done && ie;

   // Configuration registers written directly by the CPU.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dir     <= 1'b0;
         oneshot <= 1'b0;
         ie      <= 1'b0;
         period  <= '0;
         limit   <= '0;
      end else begin
         if (wr_ctrl) begin
            dir     <= writedata[1];
            oneshot <= writedata[2];
            ie      <= writedata[3];
         end
         if (wr_period) period <= writedata[PRESCALE_W-1:0];
         if (wr_limit)  limit  <= writedata[COUNT_W-1:0];
      end
   end

   // Sequencer FSM: owns EN/DONE, counter, prescaler and the registered master strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         en           <= 1'b0;
         done         <= 1'b0;
         stop_pend    <= 1'b0;
         load_pend    <= 1'b0;
         count        <= '0;
         prescale     <= '0;
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         m_writedata  <= '0;
      end else begin
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         if (wr_ctrl)   en   <= writedata[0];
         // A DONE set later in this block overrides this clear.
         if (wr_status) done <= 1'b0;

         case (state)
            S_IDLE: begin
               prescale  <= '0;
               load_pend <= 1'b0;
               if (load) begin
                  count     <= load_val;
                  stop_pend <= 1'b0;
               end
               if (en_eff) begin
                  state        <= S_PUSH;
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b0;
                  m_writedata  <= {{(32-COUNT_W){1'b0}}, (load ? load_val : count)};
               end
            end

            S_RUN: begin
               if (!en_eff) begin
                  state     <= S_IDLE;
                  prescale  <= '0;
                  stop_pend <= 1'b0;
                  load_pend <= 1'b0;
                  if (load) count <= load_val;
               end else if (load) begin
                  // LOAD beats a coincident tick: the loaded value is pushed unstepped.
                  count        <= load_val;
                  prescale     <= '0;
                  stop_pend    <= 1'b0;
                  load_pend    <= 1'b0;
                  state        <= S_PUSH;
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b0;
                  m_writedata  <= {{(32-COUNT_W){1'b0}}, load_val};
               end else if (load_pend) begin
                  prescale     <= '0;
                  load_pend    <= 1'b0;
                  state        <= S_PUSH;
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b0;
                  m_writedata  <= {{(32-COUNT_W){1'b0}}, count};
               end else if (tick) begin
                  count        <= step_val;
                  stop_pend    <= step_stop;
                  prescale     <= '0;
                  state        <= S_PUSH;
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b0;
                  m_writedata  <= {{(32-COUNT_W){1'b0}}, step_val};
               end else begin
                  prescale <= prescale + PRESCALE_W'(1);
               end
            end

            S_PUSH: begin
               // The prescaler keeps running through PUSH so ticks stay PERIOD+1 apart.
               if (prescale >= period) prescale <= '0;
               else                    prescale <= prescale + PRESCALE_W'(1);
               if (load) begin
                  count     <= load_val;
                  prescale  <= '0;
                  stop_pend <= 1'b0;
               end
               if (stop_pend && !load) begin
                  state     <= S_DONE;
                  en        <= 1'b0;
                  done      <= 1'b1;
                  stop_pend <= 1'b0;
                  prescale  <= '0;
               end else if (en_eff) begin
                  state     <= S_RUN;
                  load_pend <= load;
               end else begin
                  state     <= S_IDLE;
                  prescale  <= '0;
                  load_pend <= 1'b0;
               end
            end

            S_DONE: begin
               prescale  <= '0;
               load_pend <= 1'b0;
               if (load) count <= load_val;
               if (en_eff) begin
                  state        <= S_PUSH;
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b0;
                  m_writedata  <= {{(32-COUNT_W){1'b0}}, (load ? load_val : count)};
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   // CSR read mux, zero wait states; unused bits read 0.
   always_comb begin
      readdata = '0;
      case (address)
         A_CTRL:   readdata[3:0]              = {ie, oneshot, dir, en};
         A_PERIOD: readdata[PRESCALE_W-1:0]   = period;
         A_LIMIT:  readdata[COUNT_W-1:0]      = limit;
         A_STATUS: readdata[COUNT_W:0]        = {done, count};
         default:  readdata                   = '0;
      endcase
   end

endmodule

// File: tb/tb_pio_count_sequencer.sv
// Testbench for pio_count_sequencer: directed CSR sequences with
// hand-computed PIO write streams, spacing and CSR readback values.

module tb_pio_count_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic [1:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [31:0] m_writedata;
   logic        done_irq;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          dbl_low = 0;
   int          addr_bad = 0;
   logic        prev_low = 1'b0;
   logic [31:0] wq[$];
   int          wc[$];

   int t2_exp[8] = '{0, 1, 2, 3, 4, 5, 0, 1};
   int t3_exp[4] = '{3, 2, 1, 0};

   pio_count_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .address      (address),
      .chipselect   (chipselect),
      .write_n      (write_n),
      .writedata    (writedata),
      .readdata     (readdata),
      .m_address    (m_address),
      .m_chipselect (m_chipselect),
      .m_write_n    (m_write_n),
      .m_writedata  (m_writedata),
      .done_irq     (done_irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every PIO write seen mid-cycle.
   always @(negedge clk) begin
      if (!m_write_n) begin
         wq.push_back(m_writedata);
         wc.push_back(cyc);
         if (m_address != 2'd0 || m_chipselect != 1'b1) addr_bad++;
         if (prev_low) dbl_low++;
      end
      prev_low = !m_write_n;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
      end
   endtask

   task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      address    = a;
      chipselect = 1'b1;
      #1;
      d          = readdata;
      chipselect = 1'b0;
   endtask

   task automatic clear_q();
      wq.delete();
      wc.delete();
   endtask

   task automatic wait_writes(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while (wq.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, (wq.size() < n) ? wq.size() : n, n);
   endtask

   // Returns at the negedge of the next PUSH cycle, checking the current one first.
   task automatic wait_push(input string tag, output logic [31:0] d, output int c);
      int k;
      k = 0;
      while (m_write_n && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk(tag, {31'd0, m_write_n}, 32'd0);
      d = m_writedata;
      c = cyc;
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] d;
      int          c0, c1, c2, c3;

      // 1: reset state
      repeat (2) @(negedge clk);
      chk("rst_m_write_n", {31'd0, m_write_n}, 32'd1);
      chk("rst_m_cs", {31'd0, m_chipselect}, 32'd0);
      chk("rst_m_wdata", m_writedata, 32'd0);
      chk("rst_irq", {31'd0, done_irq}, 32'd0);
      reset = 1'b0;
      csr_rd(2'd0, r); chk("rst_ctrl", r, 32'd0);
      csr_rd(2'd1, r); chk("rst_period", r, 32'd0);
      csr_rd(2'd2, r); chk("rst_limit", r, 32'd0);
      csr_rd(2'd3, r); chk("rst_status", r, 32'd0);
      repeat (4) @(negedge clk);
      chk("rst_no_writes", wq.size(), 32'd0);

      // 2: PERIOD=3, LIMIT=5, up run
      csr_wr(2'd1, 32'd3);
      csr_wr(2'd2, 32'd5);
      csr_rd(2'd1, r); chk("t2_period_rd", r, 32'd3);
      csr_rd(2'd2, r); chk("t2_limit_rd", r, 32'd5);
      clear_q();
      csr_wr(2'd0, 32'h1);
      wait_writes("t2_count", 8, 100);
      for (int i = 0; i < 8; i++)
         if (i < wq.size()) chk($sformatf("t2_val%0d", i), wq[i], t2_exp[i]);
      for (int i = 1; i < 8; i++)
         if (i < wc.size()) chk($sformatf("t2_gap%0d", i), wc[i] - wc[i-1], 32'd4);
      csr_wr(2'd0, 32'h0);
      repeat (3) @(negedge clk);

      // 3: oneshot down from 3 with IE
      clear_q();
      csr_wr(2'd0, (32'd3 << 16) | 32'h1F);
      wait_writes("t3_count", 4, 100);
      for (int i = 0; i < 4; i++)
         if (i < wq.size()) chk($sformatf("t3_val%0d", i), wq[i], t3_exp[i]);
      repeat (12) @(negedge clk);
      chk("t3_stopped", wq.size(), 32'd4);
      csr_rd(2'd3, r); chk("t3_status_done", r, 32'h0001_0000);
      csr_rd(2'd0, r); chk("t3_ctrl_en_clr", r, 32'h0000_000E);
      chk("t3_irq_set", {31'd0, done_irq}, 32'd1);
      csr_wr(2'd3, 32'd0);
      #1;
      chk("t3_irq_clr", {31'd0, done_irq}, 32'd0);
      csr_rd(2'd3, r); chk("t3_status_clr", r, 32'd0);

      // 4: PERIOD=0 up run
      csr_wr(2'd1, 32'd0);
      clear_q();
      dbl_low = 0;
      csr_wr(2'd0, 32'h11);
      wait_writes("t4_count", 6, 60);
      for (int i = 0; i < 6; i++)
         if (i < wq.size()) chk($sformatf("t4_val%0d", i), wq[i], i);
      for (int i = 1; i < 6; i++)
         if (i < wc.size()) chk($sformatf("t4_gap%0d", i), wc[i] - wc[i-1], 32'd2);
      chk("t4_no_back_to_back", dbl_low, 32'd0);
      csr_wr(2'd0, 32'h0);
      repeat (3) @(negedge clk);

      // 5: LIMIT lowered below count, then LOAD coincident with a tick
      csr_wr(2'd1, 32'd3);
      csr_wr(2'd2, 32'd10);
      csr_wr(2'd0, (32'd7 << 16) | 32'h11);
      wait_push("t5_push7", d, c0);
      chk("t5_load7", d, 32'd7);
      csr_wr(2'd2, 32'd2);
      wait_push("t5_push_wrap", d, c1);
      chk("t5_wrap0", d, 32'd0);
      chk("t5_gap_wrap", c1 - c0, 32'd4);
      @(negedge clk);
      @(negedge clk);
      csr_wr(2'd0, (32'd9 << 16) | 32'h11);
      wait_push("t5_push_load", d, c2);
      chk("t5_load_wins", d, 32'd9);
      chk("t5_gap_load", c2 - c1, 32'd4);
      @(negedge clk);
      wait_push("t5_push_after", d, c3);
      chk("t5_after_load", d, 32'd0);
      chk("t5_gap_after", c3 - c2, 32'd4);
      csr_wr(2'd0, 32'h0);
      repeat (3) @(negedge clk);

      // 6: reset during PUSH, then restart
      csr_wr(2'd0, 32'h1);
      wait_push("t6_push", d, c0);
      #2 reset = 1'b1;
      #1;
      chk("t6_wn_drop", {31'd0, m_write_n}, 32'd1);
      chk("t6_cs_drop", {31'd0, m_chipselect}, 32'd0);
      chk("t6_wdata_clr", m_writedata, 32'd0);
      csr_rd(2'd0, r); chk("t6_ctrl", r, 32'd0);
      csr_rd(2'd3, r); chk("t6_status", r, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      clear_q();
      repeat (5) @(negedge clk);
      chk("t6_idle", wq.size(), 32'd0);
      csr_wr(2'd0, 32'h1);
      wait_writes("t6_restart_count", 1, 20);
      if (wq.size() > 0) chk("t6_restart_val", wq[0], 32'd0);
      csr_wr(2'd0, 32'h0);
      repeat (3) @(negedge clk);

      chk("m_address_cs", addr_bad, 32'd0);
      chk("never_back_to_back", dbl_low, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
